arp_rx_parser: RTL and testbench



---
 rtl/arp_rx_parser_if.sv | 61 ++++++
 rtl/arp_rx_parser.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_arp_rx_parser.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/arp_rx_parser_if.sv
// -----------------------------------------------------------------------------
// arp_rx_parser_if
//   Bundles everything the ARP receive parser exchanges with its surroundings
//   except clock and reset.
//
//   Handshake semantics: the GMII side has no back-pressure. gmii_rxdv=1 marks
//   a valid byte on gmii_rxd in that cycle. Within a frame, gmii_rxdv=0 ends
//   the frame. arp_rx_done is a single-cycle strobe with no ready. The
//   arp_rx_type/grat/idx and source_mac/ip result fields are valid from the
//   strobe onward and are held until the next accepted frame.
//
//   Signals
//     local_mac    station MAC (first byte on the wire in [47:40])
//     local_ip     N_IP local IPv4 addresses, entry i at [32i+31:32i]
//     ip_valid     per-entry enable for local_ip
//     gmii_rxdv    GMII receive data valid
//     gmii_rxd     GMII receive byte
//     arp_rx_done  one-cycle pulse per accepted ARP frame
//     arp_rx_type  0 = request, 1 = reply
//     arp_rx_grat  accepted frame was gratuitous with no local match
//     arp_rx_idx   matched local_ip index (0 when no match)
//     source_mac   sender hardware address of the last accepted frame
//     source_ip    sender protocol address of the last accepted frame
//     arp_drop_cnt saturating count of ARP frames that were not accepted
//     dbg_state    current parser FSM state encoding
//
//   Modports
//     master : the environment (GMII source, configuration, result sink)
//     slave  : the parser
// -----------------------------------------------------------------------------
interface arp_rx_parser_if #(
  parameter int N_IP  = 4,
  parameter int IDX_W = 2,
  parameter int CNT_W = 16
);
  logic [47:0]        local_mac;
  logic [32*N_IP-1:0] local_ip;
  logic [N_IP-1:0]    ip_valid;
  logic               gmii_rxdv;
  logic [7:0]         gmii_rxd;
  logic               arp_rx_done;
  logic               arp_rx_type;
  logic               arp_rx_grat;
  logic [IDX_W-1:0]   arp_rx_idx;
  logic [47:0]        source_mac;
  logic [31:0]        source_ip;
  logic [CNT_W-1:0]   arp_drop_cnt;
  logic [2:0]         dbg_state;

  modport master (
    output local_mac, local_ip, ip_valid, gmii_rxdv, gmii_rxd,
    input  arp_rx_done, arp_rx_type, arp_rx_grat, arp_rx_idx,
    input  source_mac, source_ip, arp_drop_cnt, dbg_state
  );

  modport slave (
    input  local_mac, local_ip, ip_valid, gmii_rxdv, gmii_rxd,
    output arp_rx_done, arp_rx_type, arp_rx_grat, arp_rx_idx,
    output source_mac, source_ip, arp_drop_cnt, dbg_state
  );
endinterface

// File: rtl/arp_rx_parser.sv
// -----------------------------------------------------------------------------
// arp_rx_parser
//   GMII-side ARP receive parser. It walks preamble/SFD, the Ethernet header,
//   an optional single 802.1Q tag and the 28-byte ARP body. It validates every
//   ARP header field and matches TPA against N_IP enabled local addresses.
//   Accepted frames produce a one-cycle done strobe plus held result fields.
//   Frames that reached the ARP body but were not accepted bump a saturating
//   drop counter.
//
//   Ports
//     clk  clock
//     rst  asynchronous, active-high reset; the parser leaves reset in
//          WAIT_END so a frame already in flight is ignored
//     bus  arp_rx_parser_if.slave (GMII input, configuration, results)
//
//   Parameters
//     N_IP        number of local IPv4 addresses (1..16)
//     VLAN_EN     1 = skip one 802.1Q tag, 0 = treat 0x8100 as non-ARP
//     ACCEPT_GRAT 1 = accept gratuitous ARP (SPA==TPA) with no local match
//     CNT_W       drop counter width
// -----------------------------------------------------------------------------
module arp_rx_parser #(
  parameter int N_IP        = 4,
  parameter bit VLAN_EN     = 1'b1,
  parameter bit ACCEPT_GRAT = 1'b1,
  parameter int CNT_W       = 16
) (
  input logic            clk,
  input logic            rst,
  arp_rx_parser_if.slave bus
);
  localparam int IDX_W = (N_IP > 1) ? $clog2(N_IP) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRE      = 3'd1,
    S_ETH      = 3'd2,
    S_VLAN     = 3'd3,
    S_ARP      = 3'd4,
    S_WAIT_END = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [4:0]       r_cnt;
  logic [4:0]       w_cnt_next;

  // Header tracking
  logic             r_ucast_ok;
  logic             r_bcast_ok;
  logic [7:0]       r_type_hi;
  logic             r_hdr_ok;
  logic             r_oper;
  logic [47:0]      r_sha;
  logic [31:0]      r_spa;
  logic [23:0]      r_tpa;

  // Result registers
  logic             r_done;
  logic             r_type;
  logic             r_grat;
  logic [IDX_W-1:0] r_idx;
  logic [47:0]      r_smac;
  logic [31:0]      r_sip;
  logic [CNT_W-1:0] r_drop_cnt;

  // Combinational helpers
  logic [7:0]       w_mac_byte;
  logic             w_byte_ok;
  logic [15:0]      w_etype;
  logic [31:0]      w_tpa;
  logic             w_match;
  logic [IDX_W-1:0] w_match_idx;
  logic             w_self_grat;
  logic             w_accept;
  logic             w_drop;

  // local_mac byte expected at Ethernet byte position r_cnt (0..5).
  always_comb begin
    case (r_cnt[2:0])
      3'd0:    w_mac_byte = bus.local_mac[47:40];
      3'd1:    w_mac_byte = bus.local_mac[39:32];
      3'd2:    w_mac_byte = bus.local_mac[31:24];
      3'd3:    w_mac_byte = bus.local_mac[23:16];
      3'd4:    w_mac_byte = bus.local_mac[15:8];
      default: w_mac_byte = bus.local_mac[7:0];
    endcase
  end

  // Fixed ARP header bytes 0-7: HTYPE=1, PTYPE=0x0800, HLEN=6, PLEN=4, OPER 1/2.
  always_comb begin
    w_byte_ok = 1'b1;
    case (r_cnt)
      5'd0:    w_byte_ok = (bus.gmii_rxd == 8'h00);
      5'd1:    w_byte_ok = (bus.gmii_rxd == 8'h01);
      5'd2:    w_byte_ok = (bus.gmii_rxd == 8'h08);
      5'd3:    w_byte_ok = (bus.gmii_rxd == 8'h00);
      5'd4:    w_byte_ok = (bus.gmii_rxd == 8'h06);
      5'd5:    w_byte_ok = (bus.gmii_rxd == 8'h04);
      5'd6:    w_byte_ok = (bus.gmii_rxd == 8'h00);
      5'd7:    w_byte_ok = (bus.gmii_rxd == 8'h01) || (bus.gmii_rxd == 8'h02);
      default: w_byte_ok = 1'b1;
    endcase
  end

  assign w_etype     = {r_type_hi, bus.gmii_rxd};
  assign w_tpa       = {r_tpa, bus.gmii_rxd};
  assign w_self_grat = (r_spa == w_tpa);

  // Lowest enabled index wins: scan from the top so lower hits overwrite.
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    for (int i = N_IP - 1; i >= 0; i--) begin
      if (bus.ip_valid[i] && (bus.local_ip[32*i +: 32] == w_tpa)) begin
        w_match     = 1'b1;
        w_match_idx = IDX_W'(i);
      end
    end
  end

  // Next-state logic. r_cnt is the byte index within the current section.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.gmii_rxdv) begin
          w_cnt_next   = '0;
          w_state_next = (bus.gmii_rxd == 8'h55) ? S_PRE : S_WAIT_END;
        end
      end
      S_PRE: begin
        if (!bus.gmii_rxdv) begin
          w_state_next = S_IDLE;
        end else if ((r_cnt < 5'd6) && (bus.gmii_rxd == 8'h55)) begin
          w_cnt_next = r_cnt + 5'd1;
        end else if ((r_cnt == 5'd6) && (bus.gmii_rxd == 8'hD5)) begin
          w_cnt_next   = '0;
          w_state_next = S_ETH;
        end else begin
          w_state_next = S_WAIT_END;
        end
      end
      S_ETH: begin
        if (!bus.gmii_rxdv) begin
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + 5'd1;
          // Destination MAC flags cover bytes 0-5 by the time byte 6 arrives.
          if ((r_cnt == 5'd6) && !(r_ucast_ok || r_bcast_ok)) begin
            w_state_next = S_WAIT_END;
          end else if (r_cnt == 5'd13) begin
            w_cnt_next = '0;
            if (w_etype == 16'h0806) begin
              w_state_next = S_ARP;
            end else if (VLAN_EN && (w_etype == 16'h8100)) begin
              w_state_next = S_VLAN;
            end else begin
              w_state_next = S_WAIT_END;
            end
          end
        end
      end
      S_VLAN: begin
        if (!bus.gmii_rxdv) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == 5'd3) begin
          w_cnt_next   = '0;
          w_state_next = (w_etype == 16'h0806) ? S_ARP : S_WAIT_END;
        end else begin
          w_cnt_next = r_cnt + 5'd1;
        end
      end
      S_ARP: begin
        if (!bus.gmii_rxdv) begin
          // Truncated ARP body still counts as a dropped ARP frame.
          w_drop       = 1'b1;
          w_state_next = S_IDLE;
        end else if (r_cnt == 5'd27) begin
          w_state_next = S_WAIT_END;
          // Header checks all live in bytes 0-7, so r_hdr_ok is final here.
          if (r_hdr_ok && (w_match || (ACCEPT_GRAT && w_self_grat))) begin
            w_accept = 1'b1;
          end else begin
            w_drop = 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + 5'd1;
        end
      end
      S_WAIT_END: begin
        if (!bus.gmii_rxdv) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_WAIT_END;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_WAIT_END;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Header capture and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ucast_ok <= 1'b0;
      r_bcast_ok <= 1'b0;
      r_type_hi  <= '0;
      r_hdr_ok   <= 1'b0;
      r_oper     <= 1'b0;
      r_sha      <= '0;
      r_spa      <= '0;
      r_tpa      <= '0;
      r_done     <= 1'b0;
      r_type     <= 1'b0;
      r_grat     <= 1'b0;
      r_idx      <= '0;
      r_smac     <= '0;
      r_sip      <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_done <= w_accept;

      // Arm the destination MAC comparators while in preamble.
      if (r_state == S_PRE) begin
        r_ucast_ok <= 1'b1;
        r_bcast_ok <= 1'b1;
      end

      if (bus.gmii_rxdv) begin
        case (r_state)
          S_ETH: begin
            if (r_cnt < 5'd6) begin
              r_ucast_ok <= r_ucast_ok & (bus.gmii_rxd == w_mac_byte);
              r_bcast_ok <= r_bcast_ok & (bus.gmii_rxd == 8'hFF);
            end
            if (r_cnt == 5'd12) begin
              r_type_hi <= bus.gmii_rxd;
            end
            r_hdr_ok <= 1'b1;
          end
          S_VLAN: begin
            if (r_cnt == 5'd2) begin
              r_type_hi <= bus.gmii_rxd;
            end
            r_hdr_ok <= 1'b1;
          end
          S_ARP: begin
            r_hdr_ok <= r_hdr_ok & w_byte_ok;
            if (r_cnt == 5'd7) begin
              r_oper <= bus.gmii_rxd[1];  // OPER 2 (reply) -> 1
            end
            if ((r_cnt >= 5'd8) && (r_cnt <= 5'd13)) begin
              r_sha <= {r_sha[39:0], bus.gmii_rxd};
            end
            if ((r_cnt >= 5'd14) && (r_cnt <= 5'd17)) begin
              r_spa <= {r_spa[23:0], bus.gmii_rxd};
            end
            if ((r_cnt >= 5'd24) && (r_cnt <= 5'd26)) begin
              r_tpa <= {r_tpa[15:0], bus.gmii_rxd};
            end
          end
          default: ;
        endcase
      end

      if (w_accept) begin
        r_type <= r_oper;
        r_grat <= !w_match;
        r_idx  <= w_match_idx;  // already 0 when there is no match
        r_smac <= r_sha;
        r_sip  <= r_spa;
      end

      if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.arp_rx_done  = r_done;
  assign bus.arp_rx_type  = r_type;
  assign bus.arp_rx_grat  = r_grat;
  assign bus.arp_rx_idx   = r_idx;
  assign bus.source_mac   = r_smac;
  assign bus.source_ip    = r_sip;
  assign bus.arp_drop_cnt = r_drop_cnt;
  assign bus.dbg_state    = r_state;
endmodule

// File: tb/tb_arp_rx_parser.sv
module tb_arp_rx_parser;
  localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_AA_BB_CC;
  localparam logic [47:0] BCAST     = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] SRC_MAC   = 48'h00_11_22_33_44_55;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared stimulus
  logic             rxdv = 1'b0;
  logic [7:0]       rxd  = 8'h00;
  logic [3:0]       ip_valid = 4'b0000;
  logic [127:0]     local_ip = {32'hC0A8010B, 32'hC0A8010C, 32'hC0A8010B, 32'hC0A8010A};

  // main: defaults; nv: VLAN_EN=0; ng: ACCEPT_GRAT=0; c2: CNT_W=2
  arp_rx_parser_if #(.N_IP(4), .IDX_W(2), .CNT_W(16)) if_main ();
  arp_rx_parser_if #(.N_IP(4), .IDX_W(2), .CNT_W(16)) if_nv ();
  arp_rx_parser_if #(.N_IP(4), .IDX_W(2), .CNT_W(16)) if_ng ();
  arp_rx_parser_if #(.N_IP(4), .IDX_W(2), .CNT_W(2))  if_c2 ();

  arp_rx_parser #(.N_IP(4))                  u_main (.clk(clk), .rst(rst), .bus(if_main));
  arp_rx_parser #(.N_IP(4), .VLAN_EN(1'b0))  u_nv   (.clk(clk), .rst(rst), .bus(if_nv));
  arp_rx_parser #(.N_IP(4), .ACCEPT_GRAT(1'b0)) u_ng (.clk(clk), .rst(rst), .bus(if_ng));
  arp_rx_parser #(.N_IP(4), .CNT_W(2))       u_c2   (.clk(clk), .rst(rst), .bus(if_c2));

  assign if_main.local_mac = LOCAL_MAC;
  assign if_main.local_ip  = local_ip;
  assign if_main.ip_valid  = ip_valid;
  assign if_main.gmii_rxdv = rxdv;
  assign if_main.gmii_rxd  = rxd;
  assign if_nv.local_mac   = LOCAL_MAC;
  assign if_nv.local_ip    = local_ip;
  assign if_nv.ip_valid    = ip_valid;
  assign if_nv.gmii_rxdv   = rxdv;
  assign if_nv.gmii_rxd    = rxd;
  assign if_ng.local_mac   = LOCAL_MAC;
  assign if_ng.local_ip    = local_ip;
  assign if_ng.ip_valid    = ip_valid;
  assign if_ng.gmii_rxdv   = rxdv;
  assign if_ng.gmii_rxd    = rxd;
  assign if_c2.local_mac   = LOCAL_MAC;
  assign if_c2.local_ip    = local_ip;
  assign if_c2.ip_valid    = ip_valid;
  assign if_c2.gmii_rxdv   = rxdv;
  assign if_c2.gmii_rxd    = rxd;

  // scoreboard: {type, grat, idx[1:0], mac[47:0], ip[31:0]}
  logic [83:0] exp_q[$];
  logic [83:0] last_exp = '0;
  int n_tests = 0;
  int n_fail  = 0;
  int main_done = 0, nv_done = 0, ng_done = 0, c2_done = 0;
  int exp_main_done = 0, exp_nv_done = 0, exp_ng_done = 0, exp_c2_done = 0;
  int exp_drop_main = 0, exp_drop_nv = 0, exp_drop_ng = 0, exp_drop_c2 = 0;
  logic [7:0] frame[$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [83:0] mk_exp(input logic typ, input logic grat, input logic [1:0] idx,
                                         input logic [47:0] mac, input logic [31:0] ip);
    return {typ, grat, idx, mac, ip};
  endfunction

  // output monitor
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (if_main.arp_rx_done) begin
        main_done++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_done", 1'b1, 1'b0);
        end else begin
          check_eq("rx_result", {if_main.arp_rx_type, if_main.arp_rx_grat, if_main.arp_rx_idx,
                                 if_main.source_mac, if_main.source_ip}, exp_q.pop_front());
        end
      end
      if (if_nv.arp_rx_done) nv_done++;
      if (if_ng.arp_rx_done) ng_done++;
      if (if_c2.arp_rx_done) c2_done++;
    end
  end

  // driver tasks
  task automatic push_bytes(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) frame.push_back(v[8*i +: 8]);
  endtask

  task automatic build_arp(input logic [47:0] dst, input bit vlan, input logic [15:0] etype,
                           input logic [15:0] htype, input logic [7:0] plen, input logic [15:0] oper,
                           input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa);
    frame.delete();
    for (int i = 0; i < 7; i++) frame.push_back(8'h55);
    frame.push_back(8'hD5);
    push_bytes(dst, 6);
    push_bytes(SRC_MAC, 6);
    if (vlan) push_bytes(64'h8100_0064, 4);
    push_bytes(etype, 2);
    push_bytes(htype, 2);
    push_bytes(64'h0800, 2);
    push_bytes(64'h06, 1);
    push_bytes(plen, 1);
    push_bytes(oper, 2);
    push_bytes(sha, 6);
    push_bytes(spa, 4);
    push_bytes(64'h0, 6);
    push_bytes(tpa, 4);
    for (int i = 0; i < 22; i++) frame.push_back(8'($urandom_range(0, 255)));
  endtask

  // n < 0: whole frame. rst_at >= 0: pulse reset for 3 cycles from that byte.
  task automatic send_frame(input int n, input int rst_at);
    int len;
    len = (n < 0) ? frame.size() : n;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (rst_at >= 0 && i == rst_at) rst = 1'b1;
      if (rst_at >= 0 && i == rst_at + 3) rst = 1'b0;
      rxdv = 1'b1;
      rxd  = frame[i];
    end
    @(negedge clk);
    rxdv = 1'b0;
    rxd  = 8'h00;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_q_empty"}, exp_q.size(), 0);
    check_eq({tag, "_main_done"}, main_done, exp_main_done);
    check_eq({tag, "_nv_done"}, nv_done, exp_nv_done);
    check_eq({tag, "_ng_done"}, ng_done, exp_ng_done);
    check_eq({tag, "_c2_done"}, c2_done, exp_c2_done);
    check_eq({tag, "_main_drop"}, if_main.arp_drop_cnt, exp_drop_main);
    check_eq({tag, "_nv_drop"}, if_nv.arp_drop_cnt, exp_drop_nv);
    check_eq({tag, "_ng_drop"}, if_ng.arp_drop_cnt, exp_drop_ng);
    check_eq({tag, "_c2_drop"}, if_c2.arp_drop_cnt, (exp_drop_c2 > 3) ? 3 : exp_drop_c2);
  endtask

  task automatic all_drop(input int n);
    exp_drop_main += n; exp_drop_nv += n; exp_drop_ng += n; exp_drop_c2 += n;
  endtask

  task automatic all_done();
    exp_main_done++; exp_nv_done++; exp_ng_done++; exp_c2_done++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] sha;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {if_main.arp_rx_done, if_main.arp_rx_type, if_main.arp_rx_grat,
                               if_main.arp_rx_idx, if_main.source_mac, if_main.source_ip}, 0);
    check_eq("reset_drop", if_main.arp_drop_cnt, 0);
    check_eq("reset_state", if_main.dbg_state, 3'd5);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // broadcast request, TPA = local_ip[2]
    ip_valid = 4'b0100;
    sha = {16'h0011, 32'($urandom)};
    build_arp(BCAST, 0, 16'h0806, 16'h0001, 8'h04, 16'h0001, sha, 32'hC0A80101, 32'hC0A8010C);
    exp_q.push_back(mk_exp(1'b0, 1'b0, 2'd2, sha, 32'hC0A80101));
    all_done();
    send_frame(-1, -1);
    check_counts("bcast_req");

    // unicast reply in VLAN tag, TPA = local_ip[0]
    ip_valid = 4'b0001;
    sha = {16'h0022, 32'($urandom)};
    build_arp(LOCAL_MAC, 1, 16'h8100, 16'h0001, 8'h04, 16'h0002, sha, 32'hC0A80102, 32'hC0A8010A);
    // the VLAN tag already sits where the outer ethertype goes; append ARP ethertype after it
    frame.delete();
    for (int i = 0; i < 7; i++) frame.push_back(8'h55);
    frame.push_back(8'hD5);
    push_bytes(LOCAL_MAC, 6); push_bytes(SRC_MAC, 6);
    push_bytes(64'h8100_0064_0806, 6);
    push_bytes(64'h0001_0800_0604_0002, 8);
    push_bytes(sha, 6); push_bytes(32'hC0A80102, 4); push_bytes(64'h0, 6); push_bytes(32'hC0A8010A, 4);
    for (int i = 0; i < 22; i++) frame.push_back(8'($urandom_range(0, 255)));
    exp_q.push_back(mk_exp(1'b1, 1'b0, 2'd0, sha, 32'hC0A80102));
    exp_main_done++; exp_ng_done++; exp_c2_done++;
    send_frame(-1, -1);
    check_counts("vlan_reply");

    // TPA equal to local_ip[1] and local_ip[3]: lowest enabled wins
    ip_valid = 4'b1010;
    sha = {16'h0033, 32'($urandom)};
    build_arp(BCAST, 0, 16'h0806, 16'h0001, 8'h04, 16'h0001, sha, 32'hC0A80103, 32'hC0A8010B);
    exp_q.push_back(mk_exp(1'b0, 1'b0, 2'd1, sha, 32'hC0A80103));
    all_done();
    send_frame(-1, -1);
    check_counts("multi_match");

    ip_valid = 4'b0000;
    all_drop(1);
    send_frame(-1, -1);
    check_counts("no_valid_ip");

    // gratuitous request, no local match
    ip_valid = 4'b1111;
    sha = {16'h0044, 32'($urandom)};
    build_arp(BCAST, 0, 16'h0806, 16'h0001, 8'h04, 16'h0001, sha, 32'h0A000009, 32'h0A000009);
    last_exp = mk_exp(1'b0, 1'b1, 2'd0, sha, 32'h0A000009);
    exp_q.push_back(last_exp);
    exp_main_done++; exp_nv_done++; exp_c2_done++; exp_drop_ng++;
    send_frame(-1, -1);
    check_counts("gratuitous");

    // OPER = 3: dropped, results held
    build_arp(BCAST, 0, 16'h0806, 16'h0001, 8'h04, 16'h0003, SRC_MAC, 32'hC0A80104, 32'hC0A8010A);
    all_drop(1);
    send_frame(-1, -1);
    check_counts("bad_oper");
    check_eq("hold_after_drop", {if_main.arp_rx_type, if_main.arp_rx_grat, if_main.arp_rx_idx,
                                 if_main.source_mac, if_main.source_ip}, last_exp);

    // truncated after ARP byte 20 (8 preamble + 14 eth + 21 arp bytes)
    build_arp(BCAST, 0, 16'h0806, 16'h0001, 8'h04, 16'h0001, SRC_MAC, 32'hC0A80105, 32'hC0A8010A);
    all_drop(1);
    send_frame(43, -1);
    check_counts("truncated");
    check_eq("trunc_idle", if_main.dbg_state, 3'd0);

    // non-ARP ethertype and foreign unicast destination: ignored, not counted
    build_arp(BCAST, 0, 16'h0800, 16'h0001, 8'h04, 16'h0001, SRC_MAC, 32'hC0A80105, 32'hC0A8010A);
    send_frame(-1, -1);
    build_arp(48'h02_00_00_AA_BB_CD, 0, 16'h0806, 16'h0001, 8'h04, 16'h0001, SRC_MAC,
              32'hC0A80105, 32'hC0A8010A);
    send_frame(-1, -1);
    check_counts("ignored");

    // two more header errors: counter saturation on the 2-bit instance
    build_arp(BCAST, 0, 16'h0806, 16'h0002, 8'h04, 16'h0001, SRC_MAC, 32'hC0A80106, 32'hC0A8010A);
    send_frame(-1, -1);
    build_arp(BCAST, 0, 16'h0806, 16'h0001, 8'h05, 16'h0001, SRC_MAC, 32'hC0A80106, 32'hC0A8010A);
    send_frame(-1, -1);
    all_drop(2);
    check_counts("saturate");
    check_eq("c2_saturated", if_c2.arp_drop_cnt, 2'd3);

    // reset in the middle of the ARP body, released with rxdv still high
    ip_valid = 4'b0001;
    build_arp(BCAST, 0, 16'h0806, 16'h0001, 8'h04, 16'h0001, SRC_MAC, 32'hC0A80107, 32'hC0A8010A);
    exp_drop_main = 0; exp_drop_nv = 0; exp_drop_ng = 0; exp_drop_c2 = 0;
    send_frame(-1, 32);
    check_counts("mid_reset");
    check_eq("mid_reset_outputs", {if_main.arp_rx_type, if_main.arp_rx_grat, if_main.arp_rx_idx,
                                   if_main.source_mac, if_main.source_ip}, 0);

    // next valid frame is accepted
    sha = {16'h0055, 32'($urandom)};
    build_arp(BCAST, 0, 16'h0806, 16'h0001, 8'h04, 16'h0002, sha, 32'hC0A80108, 32'hC0A8010A);
    exp_q.push_back(mk_exp(1'b1, 1'b0, 2'd0, sha, 32'hC0A80108));
    all_done();
    send_frame(-1, -1);
    check_counts("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
